// File: rtl/acc_filter_unit.sv
// Accumulates valid ADC samples into units of unit_len_i samples, compares each
// unit sum to a threshold and confirms a hit after acc_confirm_i consecutive hits.
module acc_filter_unit #(
  parameter real TCQ       = 0.1,
  parameter int  ADC_WIDTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   acc_en_i,
  input  logic [ADC_WIDTH-1:0]   adc_data_i,
  input  logic                   adc_valid_i,
  input  logic [9:0]             unit_len_i,
  input  logic [ADC_WIDTH+9:0]   acc_thre_i,
  input  logic [3:0]             acc_confirm_i,
  output logic                   filter_unit_flag_o,
  output logic                   filter_acc_result_o,
  output logic [ADC_WIDTH+9:0]   filter_unit_sum_o,
  output logic                   dbg_state_o
);

  localparam int SW = ADC_WIDTH + 10;

  // Delay is a simulation-only annotation; a negative value has no meaning.
  if (TCQ < 0.0) begin : g_tcq_negative
  end

  typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;

  state_t        state;
  logic [9:0]    cnt;
  logic [9:0]    len_q;
  logic [SW-1:0] sum;
  logic [SW-1:0] done_sum;
  logic          done_q;
  logic          flag_pend;
  logic [3:0]    hit_run;

  logic          accept;
  logic          unit_end;
  logic          hit;
  logic [9:0]    len_eff;
  logic [3:0]    confirm_eff;
  logic [3:0]    hit_run_nxt;
  logic [SW-1:0] sum_nxt;

  // Sample stream: adc_data_i is taken on any edge where adc_valid_i=1 while
  // accumulating with acc_en_i=1; there is no back-pressure, so a sample
  // presented at any other time is simply ignored.
  assign accept      = (state == ACC) && acc_en_i && adc_valid_i;
  assign sum_nxt     = sum + {10'd0, adc_data_i};
  assign unit_end    = accept && ((cnt + 10'd1) == len_q);
  assign len_eff     = (unit_len_i == 10'd0) ? 10'd1 : unit_len_i;
  assign confirm_eff = (acc_confirm_i == 4'd0) ? 4'd1 : acc_confirm_i;
  assign hit         = (done_sum >= acc_thre_i);
  assign hit_run_nxt = !hit ? 4'd0 : ((hit_run == 4'hF) ? 4'hF : hit_run + 4'd1);
  assign dbg_state_o = (state == ACC);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state               <= IDLE;
      cnt                 <= '0;
      len_q               <= 10'd1;
      sum                 <= '0;
      done_sum            <= '0;
      done_q              <= 1'b0;
      flag_pend           <= 1'b0;
      hit_run             <= '0;
      filter_unit_flag_o  <= 1'b0;
      filter_acc_result_o <= 1'b0;
      filter_unit_sum_o   <= '0;
    end else begin
      // Three-stage tail: capture at k, decide at k+1, flag at k+2.
      done_q             <= unit_end;
      flag_pend          <= done_q;
      filter_unit_flag_o <= flag_pend;
      if (unit_end)
        done_sum <= sum_nxt;

      case (state)
        IDLE: begin
          if (acc_en_i) begin
            state <= ACC;
            cnt   <= '0;
            sum   <= '0;
            len_q <= len_eff;
          end
        end
        ACC: begin
          if (!acc_en_i) begin
            state <= IDLE;
            cnt   <= '0;
            sum   <= '0;
          end else if (unit_end) begin
            cnt   <= '0;
            sum   <= '0;
            len_q <= len_eff;
          end else if (accept) begin
            cnt <= cnt + 10'd1;
            sum <= sum_nxt;
          end
        end
        default: state <= IDLE;
      endcase

      // A completed unit always wins; an abandoned partial unit breaks the hit run.
      if (done_q) begin
        filter_unit_sum_o   <= done_sum;
        hit_run             <= hit_run_nxt;
        filter_acc_result_o <= (hit_run_nxt >= confirm_eff);
      end else if ((state == ACC) && !acc_en_i && (cnt != 10'd0)) begin
        hit_run             <= '0;
        filter_acc_result_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_acc_filter_unit.sv
// Directed bench for acc_filter_unit: hit/miss units, confirm runs, gapped
// samples, mid-unit abort, reset mid-pipeline and zero unit length.
module tb_acc_filter_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        acc_en = 1'b0;
  logic [15:0] adc_data = '0;
  logic        adc_valid = 1'b0;
  logic [9:0]  unit_len = 10'd4;
  logic [25:0] acc_thre = 26'd100;
  logic [3:0]  acc_confirm = 4'd1;
  logic        flag;
  logic        result;
  logic [25:0] usum;
  logic        dbg_state;

  int checks = 0;
  int errors = 0;
  int flag_count = 0;

  acc_filter_unit #(.TCQ(0.1), .ADC_WIDTH(16)) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .acc_en_i            (acc_en),
    .adc_data_i          (adc_data),
    .adc_valid_i         (adc_valid),
    .unit_len_i          (unit_len),
    .acc_thre_i          (acc_thre),
    .acc_confirm_i       (acc_confirm),
    .filter_unit_flag_o  (flag),
    .filter_acc_result_o (result),
    .filter_unit_sum_o   (usum),
    .dbg_state_o         (dbg_state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (flag === 1'b1) flag_count++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Apply inputs, take one rising edge, settle just past it.
  task automatic drive(input logic en, input logic vld, input logic [15:0] d);
    acc_en    = en;
    adc_valid = vld;
    adc_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(1'b1, 1'b1, 16'd500);
    drive(1'b1, 1'b1, 16'd500);
    checks++; if (flag !== 1'b0) begin errors++; $display("FAIL reset_flag: got %0b expected 0", flag); end
    checks++; if (result !== 1'b0) begin errors++; $display("FAIL reset_result: got %0b expected 0", result); end
    checks++; if (usum !== 26'd0) begin errors++; $display("FAIL reset_sum: got %0d expected 0", usum); end
    checks++; if (dbg_state !== 1'b0) begin errors++; $display("FAIL reset_state: got %0b expected 0", dbg_state); end
    rst = 1'b0;
  endtask

  task automatic test_hit;
    int fc0;
    unit_len = 10'd4; acc_thre = 26'd100; acc_confirm = 4'd1;
    drive(1'b1, 1'b0, 16'd0);
    checks++; if (dbg_state !== 1'b1) begin errors++; $display("FAIL hit_enter_acc: got %0b expected 1", dbg_state); end
    fc0 = flag_count;
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 16'd30);
    checks++; if (flag !== 1'b0) begin errors++; $display("FAIL hit_flag_at_k: got %0b expected 0", flag); end
    drive(1'b1, 1'b0, 16'd0);
    checks++; if (usum !== 26'd120) begin errors++; $display("FAIL hit_sum: got %0d expected 120", usum); end
    checks++; if (result !== 1'b1) begin errors++; $display("FAIL hit_result_k1: got %0b expected 1", result); end
    checks++; if (flag !== 1'b0) begin errors++; $display("FAIL hit_flag_k1: got %0b expected 0", flag); end
    drive(1'b1, 1'b0, 16'd0);
    checks++; if (flag !== 1'b1) begin errors++; $display("FAIL hit_flag_k2: got %0b expected 1", flag); end
    checks++; if (result !== 1'b1) begin errors++; $display("FAIL hit_result_k2: got %0b expected 1", result); end
    drive(1'b1, 1'b0, 16'd0);
    checks++; if (flag !== 1'b0) begin errors++; $display("FAIL hit_flag_k3: got %0b expected 0", flag); end
    drive(1'b1, 1'b0, 16'd0);
    checks++; if (flag_count - fc0 !== 1) begin errors++; $display("FAIL hit_flag_count: got %0d expected 1", flag_count - fc0); end
  endtask

  task automatic test_miss;
    int fc0;
    fc0 = flag_count;
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 16'd10);
    drive(1'b1, 1'b0, 16'd0);
    checks++; if (usum !== 26'd40) begin errors++; $display("FAIL miss_sum: got %0d expected 40", usum); end
    checks++; if (result !== 1'b0) begin errors++; $display("FAIL miss_result: got %0b expected 0", result); end
    drive(1'b1, 1'b0, 16'd0);
    checks++; if (flag !== 1'b1) begin errors++; $display("FAIL miss_flag_k2: got %0b expected 1", flag); end
    drive(1'b1, 1'b0, 16'd0);
    drive(1'b1, 1'b0, 16'd0);
    checks++; if (flag_count - fc0 !== 1) begin errors++; $display("FAIL miss_flag_count: got %0d expected 1", flag_count - fc0); end
  endtask

  // Back-to-back two-sample units with valid held high throughout.
  task automatic test_confirm;
    logic [15:0] d [6];
    logic [25:0] es [6];
    logic        er [6];
    int fc0;
    d  = '{16'd60, 16'd60, 16'd10, 16'd60, 16'd60, 16'd60};
    es = '{26'd120, 26'd120, 26'd20, 26'd120, 26'd120, 26'd120};
    er = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    drive(1'b0, 1'b0, 16'd0);
    unit_len = 10'd2; acc_thre = 26'd100; acc_confirm = 4'd3;
    drive(1'b1, 1'b0, 16'd0);
    fc0 = flag_count;
    for (int j = 0; j < 6; j++) begin
      drive(1'b1, 1'b1, d[j]);
      if (j > 0) begin
        checks++; if (usum !== es[j-1]) begin errors++; $display("FAIL confirm_sum[%0d]: got %0d expected %0d", j-1, usum, es[j-1]); end
        checks++; if (result !== er[j-1]) begin errors++; $display("FAIL confirm_result[%0d]: got %0b expected %0b", j-1, result, er[j-1]); end
      end
      drive(1'b1, 1'b1, d[j]);
    end
    drive(1'b1, 1'b0, 16'd0);
    checks++; if (usum !== es[5]) begin errors++; $display("FAIL confirm_sum[5]: got %0d expected %0d", usum, es[5]); end
    checks++; if (result !== er[5]) begin errors++; $display("FAIL confirm_result[5]: got %0b expected %0b", result, er[5]); end
    drive(1'b1, 1'b0, 16'd0);
    drive(1'b1, 1'b0, 16'd0);
    checks++; if (flag_count - fc0 !== 6) begin errors++; $display("FAIL confirm_flag_count: got %0d expected 6", flag_count - fc0); end
  endtask

  task automatic test_gapped;
    int fc0;
    drive(1'b0, 1'b0, 16'd0);
    unit_len = 10'd8; acc_thre = 26'd100; acc_confirm = 4'd1;
    drive(1'b1, 1'b0, 16'd0);
    fc0 = flag_count;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 1'b1, 16'(i * 5));
      if (i < 8) drive(1'b1, 1'b0, 16'd999);
    end
    checks++; if (flag !== 1'b0) begin errors++; $display("FAIL gap_flag_k: got %0b expected 0", flag); end
    drive(1'b1, 1'b0, 16'd777);
    checks++; if (usum !== 26'd180) begin errors++; $display("FAIL gap_sum: got %0d expected 180", usum); end
    checks++; if (flag !== 1'b0) begin errors++; $display("FAIL gap_flag_k1: got %0b expected 0", flag); end
    drive(1'b1, 1'b0, 16'd777);
    checks++; if (flag !== 1'b1) begin errors++; $display("FAIL gap_flag_k2: got %0b expected 1", flag); end
    checks++; if (result !== 1'b1) begin errors++; $display("FAIL gap_result: got %0b expected 1", result); end
    drive(1'b1, 1'b0, 16'd0);
    checks++; if (flag_count - fc0 !== 1) begin errors++; $display("FAIL gap_flag_count: got %0d expected 1", flag_count - fc0); end
  endtask

  task automatic test_abort;
    int fc0;
    drive(1'b0, 1'b0, 16'd0);
    unit_len = 10'd4; acc_thre = 26'd100; acc_confirm = 4'd1;
    drive(1'b1, 1'b0, 16'd0);
    fc0 = flag_count;
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 16'd50);
    drive(1'b0, 1'b1, 16'd50);
    checks++; if (result !== 1'b0) begin errors++; $display("FAIL abort_result: got %0b expected 0", result); end
    checks++; if (dbg_state !== 1'b0) begin errors++; $display("FAIL abort_state: got %0b expected 0", dbg_state); end
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 16'd0);
    checks++; if (flag_count - fc0 !== 0) begin errors++; $display("FAIL abort_no_flag: got %0d expected 0", flag_count - fc0); end
    drive(1'b1, 1'b0, 16'd0);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 16'd20);
    drive(1'b1, 1'b0, 16'd0);
    checks++; if (usum !== 26'd80) begin errors++; $display("FAIL abort_next_sum: got %0d expected 80", usum); end
    checks++; if (result !== 1'b0) begin errors++; $display("FAIL abort_next_result: got %0b expected 0", result); end
    drive(1'b1, 1'b0, 16'd0);
    checks++; if (flag !== 1'b1) begin errors++; $display("FAIL abort_next_flag: got %0b expected 1", flag); end
    drive(1'b1, 1'b0, 16'd0);
  endtask

  task automatic test_reset_mid;
    int fc0;
    fc0 = flag_count;
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 16'd50);
    rst = 1'b1;
    drive(1'b1, 1'b1, 16'd50);
    rst = 1'b0;
    checks++; if (flag !== 1'b0) begin errors++; $display("FAIL rstmid_flag: got %0b expected 0", flag); end
    checks++; if (result !== 1'b0) begin errors++; $display("FAIL rstmid_result: got %0b expected 0", result); end
    checks++; if (usum !== 26'd0) begin errors++; $display("FAIL rstmid_sum: got %0d expected 0", usum); end
    checks++; if (dbg_state !== 1'b0) begin errors++; $display("FAIL rstmid_state: got %0b expected 0", dbg_state); end
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 16'd0);
    checks++; if (flag_count - fc0 !== 0) begin errors++; $display("FAIL rstmid_no_flag: got %0d expected 0", flag_count - fc0); end
  endtask

  // Zero length acts as one: every valid sample is its own unit.
  task automatic test_len_zero;
    logic [15:0] d [5];
    logic        er [5];
    int fc0;
    d  = '{16'd150, 16'd50, 16'd200, 16'd10, 16'd120};
    er = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    unit_len = 10'd0; acc_thre = 26'd100; acc_confirm = 4'd1;
    drive(1'b1, 1'b0, 16'd0);
    fc0 = flag_count;
    for (int i = 0; i < 7; i++) begin
      if (i < 5) drive(1'b1, 1'b1, d[i]);
      else drive(1'b1, 1'b0, 16'd0);
      if (i >= 1 && i <= 5) begin
        checks++; if (usum !== 26'(d[i-1])) begin errors++; $display("FAIL len0_sum[%0d]: got %0d expected %0d", i-1, usum, d[i-1]); end
        checks++; if (result !== er[i-1]) begin errors++; $display("FAIL len0_result[%0d]: got %0b expected %0b", i-1, result, er[i-1]); end
      end
      if (i >= 2) begin
        checks++; if (flag !== 1'b1) begin errors++; $display("FAIL len0_flag[%0d]: got %0b expected 1", i-2, flag); end
      end
    end
    drive(1'b1, 1'b0, 16'd0);
    checks++; if (flag !== 1'b0) begin errors++; $display("FAIL len0_flag_end: got %0b expected 0", flag); end
    checks++; if (flag_count - fc0 !== 5) begin errors++; $display("FAIL len0_flag_count: got %0d expected 5", flag_count - fc0); end
  endtask

  initial begin
    test_reset;
    test_hit;
    test_miss;
    test_confirm;
    test_gapped;
    test_abort;
    test_reset_mid;
    test_len_zero;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
